// File: rtl/cpu_reg_package.sv
// Shared bus widths, mailbox register offsets and control/status bit layout.
package cpu_reg_package;

   localparam int address_width = 16;
   localparam int data_width    = 32;

   localparam int off_txdata  = 0;
   localparam int off_rxdata  = 1;
   localparam int off_status  = 2;
   localparam int off_control = 3;

   localparam int ctl_flush  = 0;
   localparam int ctl_pop    = 1;
   localparam int ctl_clear  = 2;
   localparam int ctl_irq_en = 3;

   function automatic logic [data_width-1:0] pack_status(
      input logic       tx_full,
      input logic       tx_empty,
      input logic       rx_full,
      input logic       rx_empty,
      input logic       tx_ovf,
      input logic       rx_unf,
      input logic       irq_en,
      input logic [7:0] rx_count
   );
      logic [data_width-1:0] s;
      s       = '0;
      s[0]    = tx_full;
      s[1]    = tx_empty;
      s[2]    = rx_full;
      s[3]    = rx_empty;
      s[4]    = tx_ovf;
      s[5]    = rx_unf;
      s[6]    = irq_en;
      s[15:8] = rx_count;
      return s;
   endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with flush; pop of a full FIFO frees room for a same-cycle push.
module sync_fifo #(
   parameter int depth = 8,
   parameter int width = 32,
   localparam int aw = $clog2(depth),
   localparam int cw = aw + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [width-1:0] din,
   output logic             full,
   output logic             empty,
   output logic [cw-1:0]    count,
   output logic [width-1:0] head
);

   logic [width-1:0] mem [depth];
   logic [aw-1:0]    rd_ptr;
   logic [aw-1:0]    wr_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == cw'(depth));
   assign empty   = (count == '0);
   assign head    = mem[rd_ptr];
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + aw'(1);
         if (do_pop)  rd_ptr <= rd_ptr + aw'(1);
         unique case ({do_push, do_pop})
            2'b10:   count <= count + cw'(1);
            2'b01:   count <= count - cw'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage is deliberately left out of reset; only pointers define validity.
   always_ff @(posedge clk) begin
      if (do_push && !flush && !reset) mem[wr_ptr] <= din;
   end

endmodule

// File: rtl/bus_mailbox_responder.sv
// Four-register bus mailbox: TX FIFO toward fabric logic, RX FIFO toward the CPU.
module bus_mailbox_responder
   import cpu_reg_package::*;
#(
   parameter int base_address = 0,
   parameter int fifo_depth   = 8,
   localparam int cw = $clog2(fifo_depth) + 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     we_i,
   input  logic [address_width-1:0] address_i,
   input  logic [data_width-1:0]    data_i,
   output logic [data_width-1:0]    data_o,
   output logic [data_width-1:0]    tx_data_o,
   output logic                     tx_valid_o,
   input  logic                     tx_ready_i,
   input  logic [data_width-1:0]    rx_data_i,
   input  logic                     rx_valid_i,
   output logic                     rx_ready_o,
   output logic                     irq_o
);

   localparam logic [address_width-1:0] a_tx  = address_width'(base_address + off_txdata);
   localparam logic [address_width-1:0] a_rx  = address_width'(base_address + off_rxdata);
   localparam logic [address_width-1:0] a_st  = address_width'(base_address + off_status);
   localparam logic [address_width-1:0] a_ctl = address_width'(base_address + off_control);

   logic                  tx_full, tx_empty, rx_full, rx_empty;
   logic [cw-1:0]         tx_count, rx_count;
   logic [data_width-1:0] rx_head;
   logic                  tx_wr, ctl_wr, flush, tx_pop, rx_pop, rx_push;
   logic                  tx_drop, rx_unf_set, clear;
   logic                  tx_ovf, rx_unf, irq_en;
   logic [data_width-1:0] rd_value;

   assign tx_wr  = we_i && (address_i == a_tx);
   assign ctl_wr = we_i && (address_i == a_ctl);
   assign flush  = ctl_wr && data_i[ctl_flush];
   assign rx_pop = ctl_wr && data_i[ctl_pop];
   assign clear  = ctl_wr && data_i[ctl_clear];

   // Handshakes are masked during reset so nothing completes in that cycle.
   assign tx_valid_o = (tx_count != '0) && !reset_i;
   assign rx_ready_o = !rx_full && !reset_i;
   assign tx_pop     = tx_valid_o && tx_ready_i;
   assign rx_push    = rx_valid_i && rx_ready_o;

   assign tx_drop    = tx_wr && tx_full && !tx_pop;
   assign rx_unf_set = rx_pop && rx_empty;

   sync_fifo #(.depth(fifo_depth), .width(data_width)) u_tx_fifo (
      .clk   (clk_i),
      .reset (reset_i),
      .push  (tx_wr),
      .pop   (tx_pop),
      .flush (flush),
      .din   (data_i),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count),
      .head  (tx_data_o)
   );

   sync_fifo #(.depth(fifo_depth), .width(data_width)) u_rx_fifo (
      .clk   (clk_i),
      .reset (reset_i),
      .push  (rx_push),
      .pop   (rx_pop),
      .flush (flush),
      .din   (rx_data_i),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count),
      .head  (rx_head)
   );

   always_comb begin
      rd_value = '0;
      if (address_i == a_rx) begin
         rd_value = rx_empty ? '0 : rx_head;
      end else if (address_i == a_st) begin
         rd_value = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                tx_ovf, rx_unf, irq_en, 8'(rx_count));
      end
   end

   // A same-cycle set beats a clear on the sticky flags.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         tx_ovf <= 1'b0;
         rx_unf <= 1'b0;
         irq_en <= 1'b0;
         data_o <= '0;
         irq_o  <= 1'b0;
      end else begin
         tx_ovf <= (tx_ovf && !clear) || tx_drop;
         rx_unf <= (rx_unf && !clear) || rx_unf_set;
         if (ctl_wr) irq_en <= data_i[ctl_irq_en];
         data_o <= rd_value;
         irq_o  <= irq_en && (!rx_empty || tx_ovf || rx_unf);
      end
   end

endmodule

// File: tb/tb_bus_mailbox_responder.sv
// Randomized bench: a queue-based mailbox model predicts outputs, a monitor scores them.
module tb_bus_mailbox_responder;

   localparam int base  = 4;
   localparam int depth = 8;
   localparam int ncyc  = 4000;

   logic        clk = 1'b0;
   logic        reset_i = 1'b1;
   logic        we_i = 1'b0;
   logic [15:0] address_i = '0;
   logic [31:0] data_i = '0;
   logic [31:0] data_o;
   logic [31:0] tx_data_o;
   logic        tx_valid_o;
   logic        tx_ready_i = 1'b0;
   logic [31:0] rx_data_i = '0;
   logic        rx_valid_i = 1'b0;
   logic        rx_ready_o;
   logic        irq_o;

   always #5 clk = ~clk;

   bus_mailbox_responder #(.base_address(base), .fifo_depth(depth)) dut (
      .clk_i      (clk),
      .reset_i    (reset_i),
      .we_i       (we_i),
      .address_i  (address_i),
      .data_i     (data_i),
      .data_o     (data_o),
      .tx_data_o  (tx_data_o),
      .tx_valid_o (tx_valid_o),
      .tx_ready_i (tx_ready_i),
      .rx_data_i  (rx_data_i),
      .rx_valid_i (rx_valid_i),
      .rx_ready_o (rx_ready_o),
      .irq_o      (irq_o)
   );

   typedef struct {logic tv; logic [31:0] td; logic rr;} cur_t;
   typedef struct {logic [31:0] d; logic irq;} reg_t;

   cur_t        cur_q[$];
   reg_t        reg_q[$];
   logic [31:0] exp_tx[$];

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Monitor: samples 2 time units after the falling edge, once inputs have settled.
   always @(negedge clk) begin
      cur_t c;
      reg_t r;
      logic [31:0] t;
      #2;
      if (cur_q.size() > 0) begin
         c = cur_q.pop_front();
         chk("tx_valid", 32'(tx_valid_o), 32'(c.tv));
         chk("rx_ready", 32'(rx_ready_o), 32'(c.rr));
         if (c.tv) chk("tx_data_head", tx_data_o, c.td);
      end
      if (reg_q.size() > 1) begin
         r = reg_q.pop_front();
         chk("data_o", data_o, r.d);
         chk("irq_o", 32'(irq_o), 32'(r.irq));
      end
      if (tx_valid_o && tx_ready_i) begin
         if (exp_tx.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL tx_handshake: got %h expected no transfer", tx_data_o);
         end else begin
            t = exp_tx.pop_front();
            chk("tx_handshake", tx_data_o, t);
         end
      end
   end

   initial begin
      logic [31:0] txq[$];
      logic [31:0] rxq[$];
      logic        ovf, unf, ien;
      logic        tx_hs, rx_rdy, txw, ctl, fl, pp, clr, drop, unf_set;
      logic [31:0] rv, d;
      int          ph, off, prd, prv;
      ovf = 0; unf = 0; ien = 0;

      for (int cyc = 0; cyc < ncyc; cyc++) begin
         @(negedge clk);
         ph = (cyc / 500) % 4;
         case (ph)
            0: begin prd = 90; prv = 30; end
            1: begin prd = 10; prv = 85; end
            2: begin prd = 0;  prv = 20; end
            default: begin prd = 50; prv = 50; end
         endcase
         reset_i    = (cyc < 2) || ($urandom_range(0, 299) == 0);
         tx_ready_i = ($urandom_range(0, 99) < prd);
         rx_valid_i = ($urandom_range(0, 99) < prv);
         rx_data_i  = $urandom;
         we_i       = $urandom_range(0, 1);
         off        = (ph == 2 && $urandom_range(0, 9) < 6) ? 0 : $urandom_range(0, 5) - 1;
         address_i  = 16'(base + off);
         d          = $urandom;
         if (off == 3) begin
            d = 32'($urandom_range(0, 15));
            if (d[0] && $urandom_range(0, 9) != 0) d[0] = 1'b0;
         end
         data_i = d;

         if (reset_i) begin
            cur_q.push_back('{tv: 1'b0, td: '0, rr: 1'b0});
            reg_q.push_back('{d: '0, irq: 1'b0});
            txq.delete();
            rxq.delete();
            ovf = 0; unf = 0; ien = 0;
            continue;
         end

         rx_rdy = (rxq.size() < depth);
         cur_q.push_back('{tv: (txq.size() > 0), td: (txq.size() > 0) ? txq[0] : '0, rr: rx_rdy});

         rv = '0;
         if (off == 1 && rxq.size() > 0) rv = rxq[0];
         if (off == 2) begin
            rv[0] = (txq.size() == depth);
            rv[1] = (txq.size() == 0);
            rv[2] = (rxq.size() == depth);
            rv[3] = (rxq.size() == 0);
            rv[4] = ovf;
            rv[5] = unf;
            rv[6] = ien;
            rv[15:8] = 8'(rxq.size());
         end
         reg_q.push_back('{d: rv, irq: ien && (rxq.size() > 0 || ovf || unf)});

         tx_hs = tx_ready_i && (txq.size() > 0);
         if (tx_hs) exp_tx.push_back(txq[0]);
         txw     = we_i && off == 0;
         ctl     = we_i && off == 3;
         fl      = ctl && d[0];
         pp      = ctl && d[1];
         clr     = ctl && d[2];
         drop    = txw && (txq.size() == depth) && !tx_hs;
         unf_set = pp && (rxq.size() == 0);

         if (fl) begin
            txq.delete();
            rxq.delete();
         end else begin
            if (tx_hs) void'(txq.pop_front());
            if (txw && !drop) txq.push_back(d);
            if (pp && rxq.size() > 0) void'(rxq.pop_front());
            if (rx_valid_i && rx_rdy) rxq.push_back(rx_data_i);
         end
         ovf = (ovf && !clr) || drop;
         unf = (unf && !clr) || unf_set;
         if (ctl) ien = d[3];
      end

      @(negedge clk);
      we_i = 1'b0;
      tx_ready_i = 1'b0;
      rx_valid_i = 1'b0;
      repeat (2) @(negedge clk);
      #4;
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/bus_mailbox_responder.md
BUS_MAILBOX_RESPONDER -- requirements
Module: bus_mailbox_responder

Interface
REQ-001 SHALL have parameter base_address, default 0: first of four consecutive word addresses decoded by this block.
REQ-002 SHALL have parameter fifo_depth, default 8: entries per direction FIFO; power of two, 2..256.
REQ-003 SHALL have port clk_i, input, 1: single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port we_i, input, 1: bus write strobe, one per cycle held high.
REQ-006 SHALL have port address_i, input, address_width: bus address.
REQ-007 SHALL have port data_i, input, data_width: bus write data.
REQ-008 SHALL have port data_o, output, data_width: bus read data.
REQ-009 SHALL have ports tx_data_o (data_width), tx_valid_o (1) out, tx_ready_i (1) in: CPU-to-logic stream.
REQ-010 SHALL have ports rx_data_i (data_width), rx_valid_i (1) in, rx_ready_o (1) out: logic-to-CPU stream.
REQ-011 SHALL have port irq_o, output, 1: level interrupt.

Function
REQ-012 SHALL decode base+0 TXDATA (W push), base+1 RXDATA (R head), base+2 STATUS (R), base+3 CONTROL (W).
REQ-013 SHALL push data_i into TX FIFO when we_i high and address_i==base+0 and TX not full; write while full dropped, sets sticky tx_ovf.
REQ-014 SHALL present TX FIFO head on tx_data_o with tx_valid_o = TX not empty; pop on tx_valid_o && tx_ready_i.
REQ-015 SHALL push rx_data_i on rx_valid_i && rx_ready_o; rx_ready_o = RX not full.
REQ-016 SHALL pop RX FIFO only on write to CONTROL with bit1 set; pop while empty ignored, sets sticky rx_unf.
REQ-017 SHALL register data_o: value for address presented in cycle N appears in cycle N+1; non-decoded addresses return 0.
REQ-018 SHALL return RX head on RXDATA read; 0 when RX empty.
REQ-019 STATUS SHALL be: bit0 tx_full, bit1 tx_empty, bit2 rx_full, bit3 rx_empty, bit4 tx_ovf, bit5 rx_unf, bit6 irq_en, bits[15:8] rx count, rest 0.
REQ-020 CONTROL write SHALL act: bit0 flush both FIFOs, bit1 pop RX, bit2 clear sticky flags, bit3 irq_en value (stored).
REQ-021 Flush SHALL take priority over any same-cycle push/pop in both FIFOs; after flush counts are 0.
REQ-022 Simultaneous push and pop on a full FIFO SHALL succeed both (count unchanged); on empty FIFO pop is ignored, push succeeds.
REQ-023 Pointers SHALL wrap modulo fifo_depth; counts SHALL be $clog2(fifo_depth)+1 bits, saturating never required.
REQ-024 irq_o SHALL be registered: irq_en && (!rx_empty || tx_ovf || rx_unf), one-cycle latency.
REQ-025 Sticky flag set and clear in same cycle SHALL leave flag set.

Reset
REQ-026 reset_i SHALL empty both FIFOs, clear pointers, counts, tx_ovf, rx_unf, irq_en.
REQ-027 During/after reset: data_o=0, tx_valid_o=0, rx_ready_o=0 while reset_i high, irq_o=0; FIFO RAM contents not reset.
REQ-028 Reset mid-transfer SHALL discard in-flight data with no handshake completing in the reset cycle.

Structure
REQ-029 address_width, data_width SHALL come from cpu_reg_package; register offsets as localparams in that package.
REQ-030 Both FIFOs SHALL be instances of one sub-module sync_fifo (push, pop, flush, full, empty, count, head).

Verification
REQ-031 Write 0xA5 to base+0, tx_ready_i=1 -> tx_valid_o next cycle, tx_data_o=0xA5, TX empty after handshake.
REQ-032 fifo_depth=8, 9 TX writes with tx_ready_i=0 -> 8 stored, STATUS bit0=1, bit4=1, irq_o=1 if irq_en set.
REQ-033 rx_valid_i with 0x11,0x22 -> RXDATA read returns 0x11 one cycle later; CONTROL=0x2 -> next read 0x22; third pop sets rx_unf.
REQ-034 CONTROL=0x1 same cycle as rx push and TX handshake -> all counts 0, STATUS=0x0A.
REQ-035 reset_i asserted with 3 entries in each FIFO -> STATUS=0x0A, irq_o=0, tx_valid_o=0 next cycle.
REQ-036 Read unmapped address base+4 -> data_o=0 next cycle.
